// File: rtl/mac_tx_framer.sv
// Ethernet II transmit framer: emits the 14-byte header, streams the payload with
// ready/valid, zero-pads to the minimum frame size and enforces the inter-frame gap.
module mac_tx_framer #(
  parameter int IFG_CYCLES  = 12,
  parameter int MIN_PAYLOAD = 46,
  parameter int MAX_PAYLOAD = 1500,
  parameter int LEN_W       = 11
) (
  input  logic             mac_tx_clk,
  input  logic             mac_tx_rstn,
  input  logic [47:0]      cfg_dst_mac,
  input  logic [47:0]      cfg_src_mac,
  input  logic [15:0]      cfg_ethertype,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [7:0]       pl_data_i,
  input  logic             pl_valid_i,
  output logic             pl_ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [7:0]       mac_tx_data,
  output logic             mac_tx_valid,
  output logic             mac_tx_sof,
  output logic             mac_tx_eof
);

  typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, PAD, IFG} state_t;

  localparam logic [LEN_W-1:0] ONE      = LEN_W'(1);
  localparam logic [LEN_W-1:0] HDR_LEFT = LEN_W'(13);
  localparam logic [LEN_W-1:0] MIN_L    = LEN_W'(MIN_PAYLOAD);
  localparam logic [LEN_W-1:0] MAX_L    = LEN_W'(MAX_PAYLOAD);
  localparam logic [LEN_W-1:0] IFG_L    = LEN_W'(IFG_CYCLES);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [111:0]     hdr_q, hdr_d;
  logic [111:0]     hdr_new;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             sof_q, sof_d;
  logic             eof_q, eof_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  assign hdr_new    = {cfg_dst_mac, cfg_src_mac, cfg_ethertype};
  assign pl_ready_o = (state_q == PAYLOAD);

  // Header byte 0 leaves on the accept edge, so HDR itself only covers bytes 1..13;
  // the header is kept as a left-shifting register, MSB byte always next on the wire.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    hdr_d   = hdr_q;
    data_d  = 8'h00;
    valid_d = 1'b0;
    sof_d   = 1'b0;
    eof_d   = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_i > MAX_L) begin
            err_d = 1'b1;
          end else begin
            data_d  = hdr_new[111:104];
            hdr_d   = {hdr_new[103:0], 8'h00};
            len_d   = len_i;
            valid_d = 1'b1;
            sof_d   = 1'b1;
            cnt_d   = HDR_LEFT;
            state_d = HDR;
          end
        end
      end
      HDR: begin
        data_d  = hdr_q[111:104];
        hdr_d   = {hdr_q[103:0], 8'h00};
        valid_d = 1'b1;
        if (cnt_q == ONE) begin
          if (len_q == '0) begin
            cnt_d   = MIN_L;
            state_d = PAD;
          end else begin
            cnt_d   = len_q;
            state_d = PAYLOAD;
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      PAYLOAD: begin
        valid_d = 1'b1;
        if (!pl_valid_i) begin
          // Underrun: close the frame with a zero byte so mac_rgmii never sees valid drop.
          eof_d   = 1'b1;
          err_d   = 1'b1;
          cnt_d   = IFG_L;
          state_d = IFG;
        end else begin
          data_d = pl_data_i;
          if (cnt_q == ONE) begin
            if (len_q >= MIN_L) begin
              eof_d   = 1'b1;
              done_d  = 1'b1;
              cnt_d   = IFG_L;
              state_d = IFG;
            end else begin
              cnt_d   = MIN_L - len_q;
              state_d = PAD;
            end
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
      end
      PAD: begin
        valid_d = 1'b1;
        if (cnt_q == ONE) begin
          eof_d   = 1'b1;
          done_d  = 1'b1;
          cnt_d   = IFG_L;
          state_d = IFG;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      IFG: begin
        // IFG_CYCLES cycles here plus the IDLE accept cycle give exactly IFG_CYCLES idle bytes.
        if (cnt_q == ONE) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge mac_tx_clk) begin
    if (!mac_tx_rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge mac_tx_clk) begin
    len_q <= len_d;
    hdr_q <= hdr_d;
  end

  assign mac_tx_data  = data_q;
  assign mac_tx_valid = valid_q;
  assign mac_tx_sof   = sof_q;
  assign mac_tx_eof   = eof_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_mac_tx_framer.sv
// Bench for mac_tx_framer: frame-level reference model (expected byte list per frame)
// compared against the DUT every cycle, plus literal expectations for the directed cases.
module tb_mac_tx_framer;
  localparam int IFG = 12;

  logic        clk = 1'b0;
  logic        rstn;
  logic [47:0] dst, src;
  logic [15:0] etype;
  logic        start;
  logic [10:0] len;
  logic [7:0]  pd;
  logic        pv;
  logic        pl_ready, busy, done, err;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_sof, tx_eof;

  always #4 clk = ~clk;

  mac_tx_framer dut (
    .mac_tx_clk   (clk),
    .mac_tx_rstn  (rstn),
    .cfg_dst_mac  (dst),
    .cfg_src_mac  (src),
    .cfg_ethertype(etype),
    .start_i      (start),
    .len_i        (len),
    .pl_data_i    (pd),
    .pl_valid_i   (pv),
    .pl_ready_o   (pl_ready),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .mac_tx_data  (tx_data),
    .mac_tx_valid (tx_valid),
    .mac_tx_sof   (tx_sof),
    .mac_tx_eof   (tx_eof)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] pay   [0:1499];
  logic [7:0] exp_b [0:1599];
  logic [7:0] cap   [0:1599];
  int  exp_n = 0, exp_rdy = 0, und = -1;
  bit  exp_ok = 1'b0;
  int  ptr = -1, gap = 0, last_gap = 0, sof_cnt = 0, eof_cnt = 0;
  int  rdy_cnt = 0, cap_n = 0, err_cnt = 0, done_cnt = 0;
  bit  have_eof = 1'b0, b2b = 1'b0, rej_pend = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference frame: header bytes MSB first, payload (or truncated payload + 0x00 on
  // underrun), then zero pad up to MIN_PAYLOAD.
  task automatic build(input int l, input int u);
    logic [111:0] h;
    h = {dst, src, etype};
    for (int i = 0; i < 14; i++) exp_b[i] = h[111-8*i -: 8];
    und = u;
    if (u >= 0) begin
      for (int i = 0; i < u; i++) exp_b[14+i] = pay[i];
      exp_b[14+u] = 8'h00;
      exp_n   = 15 + u;
      exp_ok  = 1'b0;
      exp_rdy = u + 1;
    end else begin
      for (int i = 0; i < 46; i++) exp_b[14+i] = 8'h00;
      for (int i = 0; i < l; i++) exp_b[14+i] = pay[i];
      exp_n   = 14 + ((l > 46) ? l : 46);
      exp_ok  = 1'b1;
      exp_rdy = l;
    end
  endtask

  task automatic compare();
    bit last;
    if (!rstn) begin
      ptr = -1; have_eof = 1'b0; gap = 0; rej_pend = 1'b0;
      return;
    end
    if (err)  err_cnt++;
    if (done) done_cnt++;
    if (tx_valid) begin
      if (tx_sof) begin
        sof_cnt++;
        if (have_eof) begin
          chk("ifg_min", 32'(gap >= IFG), 32'd1);
          if (b2b && sof_cnt == 2) chk("ifg_exact", gap, IFG);
          last_gap = gap;
        end
        ptr = 0; rdy_cnt = 0; cap_n = 0;
      end
      chk("in_frame", 32'(ptr >= 0 && ptr < exp_n), 32'd1);
      if (ptr < 0 || ptr >= exp_n) return;
      last = (ptr == exp_n - 1);
      chk("data", 32'(tx_data), 32'(exp_b[ptr]));
      chk("sof", 32'(tx_sof), 32'(ptr == 0));
      chk("eof", 32'(tx_eof), 32'(last));
      chk("busy_frame", 32'(busy), 32'd1);
      chk("done", 32'(done), 32'(last && exp_ok));
      chk("err", 32'(err), 32'(last && !exp_ok));
      if (last) chk("ready_cycles", rdy_cnt, exp_rdy);
      cap[ptr] = tx_data;
      cap_n = ptr + 1;
      if (last) begin
        have_eof = 1'b1; gap = 0; eof_cnt++; ptr = -1;
      end else begin
        ptr++;
      end
    end else begin
      chk("idle_bus", 32'({tx_sof, tx_eof, tx_data}), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_err", 32'(err), 32'(rej_pend));
      rej_pend = 1'b0;
      chk("valid_drop", ptr, -1);
      if (have_eof) begin
        gap++;
        chk("busy_ifg", 32'(busy), 32'(gap < IFG));
      end else begin
        chk("busy_idle", 32'(busy), 32'd0);
      end
    end
  endtask

  task automatic drive();
    if (pl_ready) begin
      pd = pay[(rdy_cnt < 1500) ? rdy_cnt : 0];
      pv = (rdy_cnt != und);
      rdy_cnt++;
    end else begin
      pv = 1'($urandom_range(0, 1));
      pd = 8'($urandom);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    drive();
  endtask

  task automatic fill_pay();
    for (int i = 0; i < 1500; i++) pay[i] = 8'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && busy; i++) tick();
    chk("idle_timeout", 32'(busy), 32'd0);
    tick();
  endtask

  task automatic run_frame(input int l, input int u);
    build(l, u);
    sof_cnt = 0; eof_cnt = 0; done_cnt = 0; err_cnt = 0;
    start = 1'b1;
    len = 11'(l);
    tick();
    start = 1'b0;
    len = 11'($urandom);
    dst = 48'({$urandom(), $urandom()});
    src = 48'({$urandom(), $urandom()});
    etype = 16'($urandom);
    for (int i = 0; i < 4000 && eof_cnt == 0; i++) tick();
    chk("frame_timeout", eof_cnt, 1);
    wait_idle();
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; len = '0; pd = '0; pv = 1'b0;
    dst = '0; src = '0; etype = '0;
    fill_pay();
    repeat (3) tick();
    chk("reset_outs", 32'({tx_valid, tx_sof, tx_eof, tx_data, busy, done, err, pl_ready}), 32'd0);
    rstn = 1'b1;
    repeat (2) tick();

    // Short frame, padded to 60 bytes
    dst = 48'hFFFF_FFFF_FFFF; src = 48'h0200_0000_0001; etype = 16'h0800;
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
    run_frame(4, -1);
    chk("short_len", cap_n, 60);
    chk("short_b0", 32'(cap[0]), 32'hFF);
    chk("short_b5", 32'(cap[5]), 32'hFF);
    chk("short_b6", 32'(cap[6]), 32'h02);
    chk("short_b11", 32'(cap[11]), 32'h01);
    chk("short_type", 32'({cap[12], cap[13]}), 32'h0800);
    chk("short_pl", 32'({cap[14], cap[15], cap[16], cap[17]}), 32'h11223344);
    chk("short_pad", 32'({cap[18], cap[59]}), 32'h0000);
    chk("short_ready", rdy_cnt, 4);
    chk("short_done", done_cnt, 1);

    fill_pay();
    run_frame(100, -1);
    chk("len100", cap_n, 114);
    chk("len100_last", 32'(cap[113]), 32'(pay[99]));
    run_frame(1500, -1);
    chk("len1500", cap_n, 1514);
    run_frame(0, -1);
    chk("len0", cap_n, 60);
    chk("len0_ready", rdy_cnt, 0);

    // Length reject
    exp_n = 0; err_cnt = 0;
    start = 1'b1; len = 11'd1501; rej_pend = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    chk("reject_err", err_cnt, 1);
    chk("reject_busy", 32'(busy), 32'd0);

    // Underrun on the 21st ready cycle
    fill_pay();
    run_frame(50, 20);
    chk("underrun_len", cap_n, 35);
    chk("underrun_b34", 32'(cap[34]), 32'h00);
    chk("underrun_ready", rdy_cnt, 21);
    chk("underrun_err", err_cnt, 1);
    chk("underrun_done", done_cnt, 0);

    // Back-to-back with start held high
    b2b = 1'b1;
    build(60, -1);
    sof_cnt = 0; eof_cnt = 0;
    start = 1'b1; len = 11'd60;
    for (int i = 0; i < 1000 && sof_cnt < 2; i++) tick();
    start = 1'b0;
    for (int i = 0; i < 1000 && eof_cnt < 2; i++) tick();
    chk("b2b_frames", eof_cnt, 2);
    chk("b2b_gap", last_gap, 12);
    chk("b2b_len", cap_n, 74);
    b2b = 1'b0;
    wait_idle();

    // Reset during payload byte 10
    build(60, -1);
    sof_cnt = 0;
    start = 1'b1; len = 11'd60;
    tick();
    start = 1'b0;
    for (int i = 0; i < 200 && !(sof_cnt >= 1 && cap_n == 25); i++) tick();
    chk("reach_pl10", cap_n, 25);
    rstn = 1'b0;
    tick();
    chk("midreset_outs", 32'({tx_valid, tx_sof, tx_eof, pl_ready, busy}), 32'd0);
    rstn = 1'b1;
    repeat (2) tick();
    run_frame(60, -1);
    chk("post_reset_len", cap_n, 74);

    // Randomized frames
    for (int f = 0; f < 12; f++) begin
      int l, u;
      dst = 48'({$urandom(), $urandom()});
      src = 48'({$urandom(), $urandom()});
      etype = 16'($urandom);
      fill_pay();
      l = $urandom_range(0, 120);
      u = ($urandom_range(0, 3) == 0 && l > 0) ? $urandom_range(0, l - 1) : -1;
      run_frame(l, u);
      repeat ($urandom_range(0, 5)) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mac_tx_framer.md
Name: mac_tx_framer

Overview:
- Builds complete Ethernet II frames on the logic side of the mac_rgmii transmit channel and drives its mac_tx_data/valid/sof/eof inputs.
- Transmit counterpart of the mac_rgmii receive stream; replaces the tied-off mac_tx_* signals in main.
- A user starts a frame with a payload length. The block inserts the 14-byte header, pulls payload bytes through a ready/valid handshake, pads short frames to 60 bytes, and enforces an inter-frame gap.
- Preamble, SFD and FCS are added by mac_rgmii, not by this block.

Parameters:
- IFG_CYCLES, 12, minimum count of valid=0 cycles between an eof byte and the next sof byte; legal range 1..255.
- MIN_PAYLOAD, 46, payload bytes below which zero padding is appended.
- MAX_PAYLOAD, 1500, largest accepted len_i.
- LEN_W, 11, width of the length field and counters.

Ports:
- mac_tx_clk  in  1  sole clock (mac_gtx_clk domain)
- mac_tx_rstn  in  1  reset, synchronous, active-low
- cfg_dst_mac  in  48  destination MAC, sampled at start
- cfg_src_mac  in  48  source MAC, sampled at start
- cfg_ethertype  in  16  EtherType, sampled at start
- start_i  in  1  request a frame
- len_i  in  LEN_W  payload byte count, sampled with start_i
- pl_data_i  in  8  payload byte
- pl_valid_i  in  1  payload byte present
- pl_ready_o  out  1  block consumes pl_data_i this cycle if pl_valid_i
- busy_o  out  1  frame or IFG in progress
- done_o  out  1  one-cycle pulse: frame sent without error
- err_o  out  1  one-cycle pulse: rejected length or payload underrun
- mac_tx_data  out  8  frame byte to mac_rgmii
- mac_tx_valid  out  1  byte valid
- mac_tx_sof  out  1  first byte of frame
- mac_tx_eof  out  1  last byte of frame

Behaviour:
- One clock. Reset is synchronous and active-low.
- Reset: all outputs 0 and state IDLE at the first edge with mac_tx_rstn=0.
  - Reset mid-frame truncates the frame with no eof. mac_rgmii sees valid drop.
- All mac_tx_* outputs, busy_o, done_o and err_o are registered. pl_ready_o is decoded from state/counter and is glitch-free.
- FSM states: IDLE, HDR, PAYLOAD, PAD, IFG.
- IDLE:
  - start_i=1 with len_i<=MAX_PAYLOAD: latch cfg_* and len_i, go to HDR.
  - start_i=1 with len_i>MAX_PAYLOAD: err_o pulses next cycle, stay in IDLE, no output.
  - start_i is ignored in every other state.
- HDR: 14 cycles emitting, in order:
  - dst[47:40] … dst[7:0], then src[47:40] … src[7:0], then ethertype[15:8], ethertype[7:0].
  - The first byte appears on the edge after start is accepted, with sof=1.
  - Then go to PAYLOAD if len>0, else PAD.
- PAYLOAD: pl_ready_o=1 for exactly len cycles. A byte accepted in cycle t appears on mac_tx_data at t+1.
  - Underrun (pl_ready_o=1 and pl_valid_i=0): the next output byte is 0x00 with eof=1 and err_o=1, no done_o, then go to IFG.
  - After the last payload byte:
    - len>=MIN_PAYLOAD: that byte carries eof and the FSM goes to IFG.
    - otherwise: go to PAD.
- PAD: emit 0x00 for MIN_PAYLOAD-len cycles; the last one carries eof.
- Frame length is 14+max(len,MIN_PAYLOAD) bytes. mac_tx_valid stays 1 continuously from sof through eof (mac_rgmii has no back-pressure).
- done_o pulses in the same cycle as a successful eof.
- IFG: valid=0. The next frame's sof occurs no earlier than IFG_CYCLES cycles after eof. With start_i held high the gap is exactly IFG_CYCLES (IDLE counts toward it).
- busy_o is 1 from the cycle after start is accepted until the FSM returns to IDLE.
- Outside frames, sof, eof and valid are 0 and mac_tx_data is 0x00.
- Counters are LEN_W bits, count down, and never wrap: they are reloaded at every state entry.

Test Plan:
- Short-frame padding: dst=FF:FF:FF:FF:FF:FF, src=02:00:00:00:00:01, type=0x0800, len=4, payload 11 22 33 44 -> exactly 60 valid bytes.
  - sof on byte 0; bytes 0-5=FF; 6-11=src; 12-13=08 00; 14-17=11 22 33 44; 18-59=00.
  - eof and done_o on byte 59; pl_ready_o high exactly 4 cycles.
- No padding: len=100 -> 114 contiguous bytes, eof on payload byte 100, no pad bytes. len=1500 -> 1514 bytes. len=0 -> 60 bytes, pl_ready_o never asserted.
- Length reject: len=1501 -> err_o single pulse, busy_o stays 0, mac_tx_valid stays 0.
- Underrun: len=50, pl_valid_i deasserted on the 21st ready cycle -> frame byte 34 = 0x00 with eof, err_o pulse, no done_o, then IFG_CYCLES idle cycles.
- Back-to-back: start_i held high, len=60 -> eof-to-next-sof gap exactly 12 cycles with valid=0; second frame bytes identical to the first.
- Reset mid-frame: mac_tx_rstn=0 during payload byte 10 -> next edge valid/sof/eof/pl_ready_o/busy_o all 0. A start after reset release yields a clean 74-byte frame for len=60.
